mc_axi4_cmd_master: RTL and testbench

Single-beat AXI4 master that turns register-bank command pulses into memory-controller transactions. Takes address and write data from control registers. Launches one AXI4 write or read per command and returns read data and status to status registers. Sits between the AXI-lite register slave and the memory-controller AXI4 slave port, and serialises the two command sources onto one master interface.

---
 rtl/mc_axi4_cmd_pkg.sv | 30 +++
 rtl/mc_axi4_wr_channel_tracker.sv | 53 +++++
 rtl/mc_axi4_cmd_master.sv | 207 ++++++++++++++++++++
 tb/tb_mc_axi4_cmd_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_axi4_cmd_pkg.sv
// Shared types and encodings for the register-driven AXI4 command master.
package mc_axi4_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_AW_W = 3'd1,
      ST_WR_B    = 3'd2,
      ST_RD_AR   = 3'd3,
      ST_RD_R    = 3'd4
   } state_t;

   // Bit positions inside sr_mc_axi4_status
   localparam int STAT_BUSY_C    = 0;
   localparam int STAT_RESP_LO_C = 1;
   localparam int STAT_RESP_HI_C = 2;
   localparam int STAT_TMO_C     = 3;
   localparam int STAT_DROP_C    = 4;
   localparam int STAT_WR_PEND_C = 5;
   localparam int STAT_RD_PEND_C = 6;

   localparam logic [1:0] BURST_INCR_C  = 2'b01;
   localparam logic [1:0] RESP_OKAY_C   = 2'b00;
   localparam logic [1:0] RESP_SLVERR_C = 2'b10;

   // AxSIZE encoding for a full-width single beat
   function automatic logic [2:0] axsize_f(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/mc_axi4_wr_channel_tracker.sv
// Tracks AW and W channels of one write independently: each valid drops on
// its own handshake, done fires in the cycle the second channel completes.
module mc_axi4_wr_channel_tracker (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic awready,
   input  logic wready,
   output logic awvalid,
   output logic wvalid,
   output logic done
);

   logic aw_done;
   logic w_done;
   logic aw_hs;
   logic w_hs;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   // Both channels finished, either earlier or in this very cycle
   assign done  = (aw_done | aw_hs) & (w_done | w_hs);

   // Raise both valids at launch, retire each on its own handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (start) begin
         awvalid <= 1'b1;
         wvalid  <= 1'b1;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (done) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mc_axi4_cmd_master.sv
// Single-beat AXI4 master: serialises register write/read command pulses onto
// one AXI4 port and reports read data, response and sticky flags.
module mc_axi4_cmd_master
   import mc_axi4_cmd_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH_C = 32,
   parameter int AXI_DATA_WIDTH_C = 32,
   parameter int AXI_ID_WIDTH_C   = 4,
   parameter int AXI_ID_C         = 0,
   parameter int TIMEOUT_C        = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [AXI_ADDR_WIDTH_C-1:0]   cr_axi_address,
   input  logic [AXI_DATA_WIDTH_C-1:0]   cr_wdata,
   input  logic                          cmd_mc_axi4_write,
   input  logic                          cmd_mc_axi4_read,
   input  logic                          cmd_mc_axi4_clear,
   output logic [AXI_DATA_WIDTH_C-1:0]   sr_mc_axi4_rdata,
   output logic [31:0]                   sr_mc_axi4_status,
   output logic [AXI_ID_WIDTH_C-1:0]     awid,
   output logic [AXI_ADDR_WIDTH_C-1:0]   awaddr,
   output logic [7:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [AXI_DATA_WIDTH_C-1:0]   wdata,
   output logic [AXI_DATA_WIDTH_C/8-1:0] wstrb,
   output logic                          wlast,
   output logic                          wvalid,
   input  logic                          wready,
   input  logic [1:0]                    bresp,
   input  logic                          bvalid,
   output logic                          bready,
   output logic [AXI_ID_WIDTH_C-1:0]     arid,
   output logic [AXI_ADDR_WIDTH_C-1:0]   araddr,
   output logic [7:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   output logic                          arvalid,
   input  logic                          arready,
   input  logic [AXI_DATA_WIDTH_C-1:0]   rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast,
   input  logic                          rvalid,
   output logic                          rready
);

   localparam int CNT_W = $clog2(TIMEOUT_C + 1);

   state_t           state;
   logic             wr_pend;
   logic             rd_pend;
   logic             drop;
   logic             tmo;
   logic [1:0]       resp_q;
   logic [CNT_W-1:0] cnt;

   logic wr_req;
   logic rd_req;
   logic launch_wr;
   logic launch_rd;
   logic wr_done;
   logic advance;
   logic drop_set;
   logic tmo_set;
   logic rlast_unused;

   // Single beat with arlen=0: rlast carries no extra information
   assign rlast_unused = rlast;

   assign awid    = AXI_ID_WIDTH_C'(AXI_ID_C);
   assign arid    = AXI_ID_WIDTH_C'(AXI_ID_C);
   assign awlen   = 8'd0;
   assign arlen   = 8'd0;
   assign awsize  = axsize_f(AXI_DATA_WIDTH_C);
   assign arsize  = axsize_f(AXI_DATA_WIDTH_C);
   assign awburst = BURST_INCR_C;
   assign arburst = BURST_INCR_C;
   assign wstrb   = '1;
   assign wlast   = 1'b1;

   // A same-cycle pulse launches directly without passing through the flag
   assign wr_req    = wr_pend | cmd_mc_axi4_write;
   assign rd_req    = rd_pend | cmd_mc_axi4_read;
   assign launch_wr = (state == ST_IDLE) & wr_req;
   assign launch_rd = (state == ST_IDLE) & ~wr_req & rd_req;

   // Handshake that moves the FSM to its next state
   assign advance = ((state == ST_WR_AW_W) & wr_done) |
                    ((state == ST_WR_B)    & bvalid)  |
                    ((state == ST_RD_AR)   & arready) |
                    ((state == ST_RD_R)    & rvalid);

   assign drop_set = (cmd_mc_axi4_write & wr_pend) | (cmd_mc_axi4_read & rd_pend);
   assign tmo_set  = (state != ST_IDLE) & ~advance & (cnt == CNT_W'(TIMEOUT_C - 1));

   mc_axi4_wr_channel_tracker u_wr_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (launch_wr),
      .awready (awready),
      .wready  (wready),
      .awvalid (awvalid),
      .wvalid  (wvalid),
      .done    (wr_done)
   );

   // Transaction FSM with registered handshake outputs and captured results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         bready           <= 1'b0;
         arvalid          <= 1'b0;
         rready           <= 1'b0;
         awaddr           <= '0;
         araddr           <= '0;
         wdata            <= '0;
         sr_mc_axi4_rdata <= '0;
         resp_q           <= RESP_OKAY_C;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch_wr) begin
                  state  <= ST_WR_AW_W;
                  awaddr <= cr_axi_address;
                  wdata  <= cr_wdata;
               end else if (launch_rd) begin
                  state   <= ST_RD_AR;
                  arvalid <= 1'b1;
                  araddr  <= cr_axi_address;
               end
            end
            ST_WR_AW_W: begin
               if (wr_done) begin
                  state  <= ST_WR_B;
                  bready <= 1'b1;
               end
            end
            ST_WR_B: begin
               if (bvalid) begin
                  state  <= ST_IDLE;
                  bready <= 1'b0;
                  resp_q <= bresp;
               end
            end
            ST_RD_AR: begin
               if (arready) begin
                  state   <= ST_RD_R;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
               end
            end
            ST_RD_R: begin
               if (rvalid) begin
                  state            <= ST_IDLE;
                  rready           <= 1'b0;
                  sr_mc_axi4_rdata <= rdata;
                  resp_q           <= rresp;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Pending flags and sticky drop/timeout; a set event beats clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         drop    <= 1'b0;
         tmo     <= 1'b0;
      end else begin
         if (launch_wr)              wr_pend <= 1'b0;
         else if (cmd_mc_axi4_write) wr_pend <= 1'b1;
         if (launch_rd)              rd_pend <= 1'b0;
         else if (cmd_mc_axi4_read)  rd_pend <= 1'b1;
         drop <= drop_set | (drop & ~cmd_mc_axi4_clear);
         tmo  <= tmo_set  | (tmo  & ~cmd_mc_axi4_clear);
      end
   end

   // Wait counter: restarts on every state-advancing handshake, saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if ((state == ST_IDLE) || advance) begin
         cnt <= '0;
      end else if (cnt != CNT_W'(TIMEOUT_C)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Status word assembly
   always_comb begin
      sr_mc_axi4_status = '0;
      sr_mc_axi4_status[STAT_BUSY_C]                   = (state != ST_IDLE);
      sr_mc_axi4_status[STAT_RESP_HI_C:STAT_RESP_LO_C] = resp_q;
      sr_mc_axi4_status[STAT_TMO_C]                    = tmo;
      sr_mc_axi4_status[STAT_DROP_C]                   = drop;
      sr_mc_axi4_status[STAT_WR_PEND_C]                = wr_pend;
      sr_mc_axi4_status[STAT_RD_PEND_C]                = rd_pend;
   end

endmodule

// File: tb/tb_mc_axi4_cmd_master.sv
// Bench for mc_axi4_cmd_master: configurable-latency AXI4 slave, scoreboard of
// expected transactions, a vector table and hand-written corner sequences.
module tb_mc_axi4_cmd_master;
   import mc_axi4_cmd_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int TO = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [AW-1:0]   cr_axi_address;
   logic [DW-1:0]   cr_wdata;
   logic            cmd_w, cmd_r, cmd_c;
   logic [DW-1:0]   sr_rdata;
   logic [31:0]     status;
   logic [IW-1:0]   awid, arid;
   logic [AW-1:0]   awaddr, araddr;
   logic [7:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst;
   logic            awvalid, awready, wvalid, wready, wlast;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]      bresp, rresp;
   logic            bvalid, bready, arvalid, arready, rvalid, rready, rlast;
   logic [DW-1:0]   rdata;

   mc_axi4_cmd_master #(
      .AXI_ADDR_WIDTH_C (AW), .AXI_DATA_WIDTH_C (DW), .AXI_ID_WIDTH_C (IW),
      .AXI_ID_C (0), .TIMEOUT_C (TO)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .cr_axi_address (cr_axi_address), .cr_wdata (cr_wdata),
      .cmd_mc_axi4_write (cmd_w), .cmd_mc_axi4_read (cmd_r), .cmd_mc_axi4_clear (cmd_c),
      .sr_mc_axi4_rdata (sr_rdata), .sr_mc_axi4_status (status),
      .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
      .awburst (awburst), .awvalid (awvalid), .awready (awready),
      .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
      .bresp (bresp), .bvalid (bvalid), .bready (bready),
      .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
      .arburst (arburst), .arvalid (arvalid), .arready (arready),
      .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready)
   );

   // ---------------- slave model ----------------
   int aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0]    b_resp_cfg, r_resp_cfg;
   logic [DW-1:0] r_data_cfg;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic aw_seen, w_seen, ar_seen;
   int n_aw, n_w, n_b, n_ar, n_r;

   assign awready = awvalid && (aw_cnt >= aw_dly);
   assign wready  = wvalid  && (w_cnt  >= w_dly);
   assign arready = arvalid && (ar_cnt >= ar_dly);
   assign bresp   = b_resp_cfg;
   assign rresp   = r_resp_cfg;
   assign rdata   = r_data_cfg;
   assign rlast   = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0;
         n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (awvalid && awready) n_aw <= n_aw + 1;
         if (wvalid && wready)   n_w  <= n_w + 1;
         if (arvalid && arready) n_ar <= n_ar + 1;
         if (bvalid && bready) begin
            bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0; n_b <= n_b + 1;
         end else if (!bvalid && (aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
            aw_seen <= 1'b1; w_seen <= 1'b1;
            if (b_cnt >= b_dly) bvalid <= 1'b1;
            else b_cnt <= b_cnt + 1;
         end else begin
            if (awvalid && awready) aw_seen <= 1'b1;
            if (wvalid && wready)   w_seen  <= 1'b1;
         end
         if (rvalid && rready) begin
            rvalid <= 1'b0; ar_seen <= 1'b0; r_cnt <= 0; n_r <= n_r + 1;
         end else if (!rvalid && (ar_seen || (arvalid && arready))) begin
            ar_seen <= 1'b1;
            if (r_cnt >= r_dly) rvalid <= 1'b1;
            else r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          is_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    resp;
   } exp_t;
   exp_t exp_q[$];

   logic          chk_b, chk_r;
   logic [1:0]    exp_resp;
   logic [DW-1:0] exp_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic no_exp(input string name);
      checks++;
      errors++;
      $display("FAIL %s: handshake with no matching expected transaction (t=%0t)", name, $time);
   endtask

   // Scoreboard monitor: compares request fields on handshakes, results after
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (chk_b) begin
               chk("b_status_resp", 64'(status[2:1]), 64'(exp_resp));
               chk_b = 1'b0;
            end
            if (chk_r) begin
               chk("r_rdata", 64'(sr_rdata), 64'(exp_rdata));
               chk("r_status_resp", 64'(status[2:1]), 64'(exp_resp));
               chk_r = 1'b0;
            end
            if (awvalid && awready) begin
               if (exp_q.size() == 0 || exp_q[0].is_rd) no_exp("aw");
               else chk("awaddr", 64'(awaddr), 64'(exp_q[0].addr));
            end
            if (wvalid && wready) begin
               if (exp_q.size() == 0 || exp_q[0].is_rd) no_exp("w");
               else chk("wdata", 64'(wdata), 64'(exp_q[0].data));
            end
            if (bvalid && bready) begin
               if (exp_q.size() == 0 || exp_q[0].is_rd) no_exp("b");
               else begin
                  exp_resp = exp_q[0].resp;
                  void'(exp_q.pop_front());
                  chk_b = 1'b1;
               end
            end
            if (arvalid && arready) begin
               if (exp_q.size() == 0 || !exp_q[0].is_rd) no_exp("ar");
               else chk("araddr", 64'(araddr), 64'(exp_q[0].addr));
            end
            if (rvalid && rready) begin
               if (exp_q.size() == 0 || !exp_q[0].is_rd) no_exp("r");
               else begin
                  exp_resp  = exp_q[0].resp;
                  exp_rdata = exp_q[0].data;
                  void'(exp_q.pop_front());
                  chk_r = 1'b1;
               end
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic pulse(input logic w, input logic r, input logic c);
      @(negedge clk);
      cmd_w = w; cmd_r = r; cmd_c = c;
      @(negedge clk);
      cmd_w = 1'b0; cmd_r = 1'b0; cmd_c = 1'b0;
   endtask

   task automatic push(input logic is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] resp);
      exp_t e;
      e.is_rd = is_rd; e.addr = a; e.data = d; e.resp = resp;
      exp_q.push_back(e);
   endtask

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   // Waits until FSM idle with nothing pending; expired budget is a failure
   task automatic wait_idle(input string name, input int max_cyc);
      int n;
      n = 0;
      while ((status[0] || status[5] || status[6]) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (status[0] || status[5] || status[6]) begin
         errors++;
         $display("FAIL %s: still busy after %0d cycles, status=%0h", name, max_cyc, status);
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic          is_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      int            d_aw, d_w, d_b, d_ar, d_r;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int b_aw, b_w, b_b, b_ar, b_r;

      rst_n = 1'b0;
      cmd_w = 1'b0; cmd_r = 1'b0; cmd_c = 1'b0;
      cr_axi_address = '0; cr_wdata = '0;
      set_dly(0, 0, 0, 0, 0);
      b_resp_cfg = RESP_OKAY_C; r_resp_cfg = RESP_OKAY_C; r_data_cfg = '0;
      chk_b = 1'b0; chk_r = 1'b0; exp_resp = '0; exp_rdata = '0;

      vecs[0] = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0};
      vecs[1] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0};
      vecs[2] = '{1'b0, 32'h0000_2000, 32'h1234_5678, RESP_SLVERR_C, 2, 0, 3, 0, 0};
      vecs[3] = '{1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 2'b10, 0, 0, 0, 3, 2};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 2'b01, 0, 3, 0, 0, 0};
      vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 2'b11, 0, 0, 0, 0, 0};
      vecs[6] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 2'b00, 3, 3, 1, 0, 0};

      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      // Reset state and constant outputs
      chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      chk("rst_rdata", 64'(sr_rdata), 64'd0);
      chk("rst_status", 64'(status), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("const_len", 64'({awlen, arlen}), 64'd0);
      chk("const_size", 64'({awsize, arsize}), 64'({3'd2, 3'd2}));
      chk("const_burst", 64'({awburst, arburst}), 64'({2'b01, 2'b01}));
      chk("const_wstrb_wlast", 64'({wstrb, wlast}), 64'({4'hF, 1'b1}));
      chk("const_id", 64'({awid, arid}), 64'd0);

      // Zero-wait write latency
      cr_axi_address = 32'h100; cr_wdata = 32'hDEAD_BEEF;
      push(1'b0, 32'h100, 32'hDEAD_BEEF, 2'b00);
      pulse(1'b1, 1'b0, 1'b0);
      chk("lat_w_valids", 64'({awvalid, wvalid}), 64'b11);
      chk("lat_w_busy", 64'(status[0]), 64'd1);
      @(negedge clk);
      chk("lat_w_bready", 64'({bready, awvalid, wvalid}), 64'b100);
      @(negedge clk);
      chk("lat_w_idle", 64'(status[0]), 64'd0);
      wait_idle("lat_w", 20);

      // Vector table
      for (int i = 0; i < 7; i++) begin
         set_dly(vecs[i].d_aw, vecs[i].d_w, vecs[i].d_b, vecs[i].d_ar, vecs[i].d_r);
         b_resp_cfg = vecs[i].resp; r_resp_cfg = vecs[i].resp; r_data_cfg = vecs[i].data;
         cr_axi_address = vecs[i].addr; cr_wdata = vecs[i].data;
         b_aw = n_aw; b_ar = n_ar;
         push(vecs[i].is_rd, vecs[i].addr, vecs[i].data, vecs[i].resp);
         pulse(!vecs[i].is_rd, vecs[i].is_rd, 1'b0);
         wait_idle("vec", 50);
         chk("vec_n_aw", 64'(n_aw - b_aw), vecs[i].is_rd ? 64'd0 : 64'd1);
         chk("vec_n_ar", 64'(n_ar - b_ar), vecs[i].is_rd ? 64'd1 : 64'd0);
      end

      // Skewed write: W first, then AW first
      for (int s = 0; s < 2; s++) begin
         int n;
         if (s == 0) set_dly(5, 1, 0, 0, 0);
         else        set_dly(1, 5, 0, 0, 0);
         b_resp_cfg = RESP_OKAY_C;
         cr_axi_address = 32'h300 + 32'(s); cr_wdata = 32'hC0DE_0000 + 32'(s);
         b_aw = n_aw; b_w = n_w; b_b = n_b;
         push(1'b0, cr_axi_address, cr_wdata, RESP_OKAY_C);
         pulse(1'b1, 1'b0, 1'b0);
         n = 0;
         while (!(s == 0 ? (wvalid && wready) : (awvalid && awready)) && n < 20) begin
            @(negedge clk);
            n++;
         end
         @(negedge clk);
         if (s == 0) chk("skew_w_first", 64'({wvalid, awvalid}), 64'b01);
         else        chk("skew_aw_first", 64'({awvalid, wvalid}), 64'b01);
         wait_idle("skew", 30);
         chk("skew_counts", 64'({8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_b - b_b)}),
             64'({8'd1, 8'd1, 8'd1}));
      end

      // Simultaneous write and read pulses
      set_dly(0, 0, 0, 0, 0);
      cr_axi_address = 32'h400; cr_wdata = 32'h5555_AAAA;
      r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = RESP_OKAY_C; b_resp_cfg = RESP_OKAY_C;
      push(1'b0, 32'h400, 32'h5555_AAAA, 2'b00);
      push(1'b1, 32'h400, 32'h0BAD_F00D, 2'b00);
      pulse(1'b1, 1'b1, 1'b0);
      chk("sim_first", 64'({awvalid, arvalid, status[6]}), 64'b101);
      @(negedge clk);
      @(negedge clk);
      chk("sim_idle_gap", 64'({status[0], arvalid}), 64'b00);
      @(negedge clk);
      chk("sim_rd_launch", 64'({arvalid, status[6]}), 64'b10);
      wait_idle("sim", 20);
      chk("sim_drop", 64'(status[4]), 64'd0);

      // Pending write, dropped write, clear
      set_dly(8, 8, 0, 0, 0);
      cr_axi_address = 32'h500; cr_wdata = 32'h0000_0500;
      b_b = n_b;
      push(1'b0, 32'h500, 32'h500, 2'b00);
      push(1'b0, 32'h500, 32'h500, 2'b00);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      chk("pend_set", 64'({status[5], status[4]}), 64'b10);
      pulse(1'b1, 1'b0, 1'b0);
      chk("drop_set", 64'({status[5], status[4]}), 64'b11);
      pulse(1'b0, 1'b0, 1'b1);
      chk("drop_clear", 64'({status[5], status[4]}), 64'b10);
      wait_idle("drop", 80);
      chk("drop_n_b", 64'(n_b - b_b), 64'd2);

      // Timeout with slow B, SLVERR response
      set_dly(0, 0, 1100, 0, 0);
      b_resp_cfg = RESP_SLVERR_C;
      cr_axi_address = 32'h600; cr_wdata = 32'h0000_0600;
      push(1'b0, 32'h600, 32'h600, RESP_SLVERR_C);
      pulse(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 20 && !bready; n++) @(negedge clk);
      chk("tmo_in_wr_b", 64'(bready), 64'd1);
      repeat (1023) @(negedge clk);
      chk("tmo_not_yet", 64'({status[3], status[0]}), 64'b01);
      @(negedge clk);
      chk("tmo_set", 64'({status[3], status[0]}), 64'b11);
      wait_idle("tmo", 200);
      chk("tmo_resp", 64'({status[3], status[2:1]}), 64'({1'b1, 2'b10}));
      pulse(1'b0, 1'b0, 1'b1);
      chk("tmo_clear", 64'(status[3]), 64'd0);

      // Reset in the middle of WR_AW_W
      set_dly(50, 50, 0, 0, 0);
      cr_axi_address = 32'h700; cr_wdata = 32'h0000_0700;
      push(1'b0, 32'h700, 32'h700, 2'b00);
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("mid_pre", 64'({awvalid, wvalid}), 64'b11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      chk("mid_rst_status", 64'(status), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'({status[0], awvalid}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
